// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared constants for the multi-cycle controller:
//   - supported opcode encodings (R_TYPE, RTYPE_I, LW, SW)
//   - funct3/funct7 encodings of the supported operations
//   - ALU_CC_* operation codes driven onto alu_cc
//   - FSM state encoding (ctrl_state_e)
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] RTYPE_I = 7'b0010011;
  localparam logic [6:0] LW      = 7'b0000011;
  localparam logic [6:0] SW      = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_CC_AND = 4'b0000;
  localparam logic [3:0] ALU_CC_OR  = 4'b0001;
  localparam logic [3:0] ALU_CC_ADD = 4'b0010;
  localparam logic [3:0] ALU_CC_SUB = 4'b0110;
  localparam logic [3:0] ALU_CC_SLT = 4'b0111;
  localparam logic [3:0] ALU_CC_XOR = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } ctrl_state_e;

  // Loads and stores are the only instructions that pass through MEM.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Memory handshake bundle between the controller and the instruction/data
// memories.
//   fetch_req   controller -> imem : instruction fetch request
//   fetch_ready imem -> controller : instruction word returned
//   mem_read    controller -> dmem : data read request
//   mem_write   controller -> dmem : data write request
//   mem_ready   dmem -> controller : data access complete
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;

  logic fetch_req;
  logic fetch_ready;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output fetch_req,
    output mem_read,
    output mem_write,
    input  fetch_ready,
    input  mem_ready
  );

  modport slave (
    input  fetch_req,
    input  mem_read,
    input  mem_write,
    output fetch_ready,
    output mem_ready
  );

endinterface

// File: rtl/alu_cc_decode.sv
// ---------------------------------------------------------------------------
// alu_cc_decode
// Purely combinational decode of {opcode, funct7, funct3} into the ALU
// operation code and a legality flag.
//   opcode  in  7  instruction opcode
//   funct7  in  7  instruction funct7 (ignored for I-type)
//   funct3  in  3  instruction funct3
//   alu_cc  out 4  ALU operation code (don't-care when legal = 0)
//   legal   out 1  combination is supported
// ---------------------------------------------------------------------------
module alu_cc_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_cc,
  output logic       legal
);

  // R-type (base funct7) and I-type share the same funct3 -> operation map.
  logic [3:0] f3_cc;
  logic       f3_ok;

  always_comb begin
    f3_cc = ALU_CC_AND;
    f3_ok = 1'b1;
    case (funct3)
      F3_ADD:  f3_cc = ALU_CC_ADD;
      F3_SLT:  f3_cc = ALU_CC_SLT;
      F3_XOR:  f3_cc = ALU_CC_XOR;
      F3_OR:   f3_cc = ALU_CC_OR;
      F3_AND:  f3_cc = ALU_CC_AND;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_cc = ALU_CC_AND;
    legal  = 1'b0;
    case (opcode)
      R_TYPE: begin
        if (funct7 == F7_BASE) begin
          alu_cc = f3_cc;
          legal  = f3_ok;
        end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
          alu_cc = ALU_CC_SUB;
          legal  = 1'b1;
        end
      end
      RTYPE_I: begin
        alu_cc = f3_cc;
        legal  = f3_ok;
      end
      LW, SW: begin
        // Only word accesses are supported; address = rs1 + imm.
        if (funct3 == F3_SLT) begin
          alu_cc = ALU_CC_ADD;
          legal  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for data_path. Walks each instruction through
// FETCH / DECODE / EXEC / MEM / WB, holds FETCH and MEM until the memory
// handshake completes, and aborts with bus_err after MEM_TIMEOUT cycles of
// waiting.
//
// Parameters
//   MEM_TIMEOUT  cycles allowed in FETCH or MEM without ready (>= 2)
//   CNT_W        retired-counter width (only with CTRL_PERF_CNT_EN)
//
// Optional feature (macro CTRL_PERF_CNT_EN): adds output retired, a counter
// incremented on every pc_write, wrapping at 2^CNT_W.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   run        in   start fetching (sampled in IDLE only)
//   opcode     in   7  from data_path, valid in DECODE
//   funct7     in   7  from data_path, valid in DECODE
//   funct3     in   3  from data_path, valid in DECODE
//   mem_bus    master modport: fetch_req/fetch_ready, mem_read/mem_write/mem_ready
//   ir_write   out  latch IR (FETCH cycle in which fetch_ready is seen)
//   pc_write   out  PC <= PC+4 on the last cycle of a retired instruction
//   reg_write  out  register-file write enable (WB)
//   mem2reg    out  write-back selects memory data (WB of LW)
//   alu_src    out  ALU operand B = immediate
//   alu_cc     out  4  ALU operation code (EXEC..WB, else 0000)
//   busy       out  state != IDLE
//   illegal    out  1-cycle pulse after DECODE of an unsupported instruction
//   bus_err    out  1-cycle pulse after a handshake timeout
//   retired    out  CNT_W retired-instruction count (CTRL_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [6:0]        opcode,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  multicycle_ctrl_if.master mem_bus,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              mem2reg,
  output logic              alu_src,
  output logic [3:0]        alu_cc,
  output logic              busy,
  output logic              illegal,
  output logic              bus_err
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] retired
`endif
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [6:0]        opcode_reg;
  logic [6:0]        funct7_reg;
  logic [2:0]        funct3_reg;
  logic              illegal_reg, illegal_next;
  logic              bus_err_reg, bus_err_next;

  logic [6:0]        dec_opcode;
  logic [6:0]        dec_funct7;
  logic [2:0]        dec_funct3;
  logic [3:0]        dec_alu_cc;
  logic              dec_legal;

  logic              is_lw;
  logic              is_sw;
  logic              wait_expired;
  logic              fetch_req_c;
  logic              mem_read_c;
  logic              mem_write_c;

  // The decoder sees the live fields during DECODE (for the legality check)
  // and the latched fields afterwards, so alu_cc in EXEC..WB never depends
  // on whatever data_path is presenting at that time.
  assign dec_opcode = (state_reg == ST_DECODE) ? opcode : opcode_reg;
  assign dec_funct7 = (state_reg == ST_DECODE) ? funct7 : funct7_reg;
  assign dec_funct3 = (state_reg == ST_DECODE) ? funct3 : funct3_reg;

  alu_cc_decode u_alu_cc_decode (
    .opcode (dec_opcode),
    .funct7 (dec_funct7),
    .funct3 (dec_funct3),
    .alu_cc (dec_alu_cc),
    .legal  (dec_legal)
  );

  assign is_lw        = (opcode_reg == LW);
  assign is_sw        = (opcode_reg == SW);
  assign wait_expired = (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    illegal_next  = 1'b0;
    bus_err_next  = 1'b0;
    fetch_req_c   = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem2reg       = 1'b0;
    alu_src       = 1'b0;
    alu_cc        = ALU_CC_AND;

    case (state_reg)
      ST_IDLE: begin
        if (run) begin
          state_next    = ST_FETCH;
          wait_cnt_next = '0;
        end
      end

      ST_FETCH: begin
        fetch_req_c = 1'b1;
        // ready wins over the timeout so a word on the last allowed cycle
        // is still accepted.
        if (mem_bus.fetch_ready) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          bus_err_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_DECODE: begin
        if (dec_legal) begin
          state_next = ST_EXEC;
        end else begin
          illegal_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      ST_EXEC: begin
        alu_src = (opcode_reg != R_TYPE);
        alu_cc  = dec_alu_cc;
        if (is_mem_op(opcode_reg)) begin
          state_next    = ST_MEM;
          wait_cnt_next = '0;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        alu_src     = 1'b1;
        alu_cc      = dec_alu_cc;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_bus.mem_ready) begin
          // A store retires here; a load still needs its write-back.
          if (is_lw) begin
            state_next = ST_WB;
          end else begin
            pc_write   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (wait_expired) begin
          bus_err_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_WB: begin
        alu_src    = (opcode_reg != R_TYPE);
        alu_cc     = dec_alu_cc;
        reg_write  = 1'b1;
        mem2reg    = is_lw;
        pc_write   = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
      opcode_reg   <= '0;
      funct7_reg   <= '0;
      funct3_reg   <= '0;
      illegal_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      bus_err_reg  <= bus_err_next;
      if (state_reg == ST_DECODE) begin
        opcode_reg <= opcode;
        funct7_reg <= funct7;
        funct3_reg <= funct3;
      end
    end
  end

  assign busy              = (state_reg != ST_IDLE);
  assign illegal           = illegal_reg;
  assign bus_err           = bus_err_reg;
  assign mem_bus.fetch_req = fetch_req_c;
  assign mem_bus.mem_read  = mem_read_c;
  assign mem_bus.mem_write = mem_write_c;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_reg <= '0;
    end else if (pc_write) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each cycle the full output vector
//   {busy, fetch_req, ir_write, alu_src, mem_read, mem_write,
//    reg_write, mem2reg, pc_write, illegal, bus_err, alu_cc[3:0]}
// is compared against a hand-written expectation.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       run;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       ir_write, pc_write, reg_write, mem2reg, alu_src;
  logic [3:0] alu_cc;
  logic       busy, illegal, bus_err;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .funct7    (funct7),
    .funct3    (funct3),
    .mem_bus   (bus),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem2reg   (mem2reg),
    .alu_src   (alu_src),
    .alu_cc    (alu_cc),
    .busy      (busy),
    .illegal   (illegal),
    .bus_err   (bus_err)
`ifdef CTRL_PERF_CNT_EN
    , .retired (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {busy, bus.fetch_req, ir_write, alu_src, bus.mem_read, bus.mem_write,
                reg_write, mem2reg, pc_write, illegal, bus_err, alu_cc};

  //                                    bsy frq irw src mrd mwr rw m2r pc ill ber cc
  localparam logic [14:0] E_IDLE     = 15'b0_0_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [14:0] E_FETCH_R  = 15'b1_1_1_0_0_0_0_0_0_0_0_0000;
  localparam logic [14:0] E_FETCH_W  = 15'b1_1_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [14:0] E_DECODE   = 15'b1_0_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [14:0] E_ILLEGAL  = 15'b0_0_0_0_0_0_0_0_0_1_0_0000;
  localparam logic [14:0] E_BUS_ERR  = 15'b0_0_0_0_0_0_0_0_0_0_1_0000;
  localparam logic [14:0] E_ADD_EX   = 15'b1_0_0_0_0_0_0_0_0_0_0_0010;
  localparam logic [14:0] E_ADD_WB   = 15'b1_0_0_0_0_0_1_0_1_0_0_0010;
  localparam logic [14:0] E_SUB_EX   = 15'b1_0_0_0_0_0_0_0_0_0_0_0110;
  localparam logic [14:0] E_SUB_WB   = 15'b1_0_0_0_0_0_1_0_1_0_0_0110;
  localparam logic [14:0] E_XORI_EX  = 15'b1_0_0_1_0_0_0_0_0_0_0_1100;
  localparam logic [14:0] E_XORI_WB  = 15'b1_0_0_1_0_0_1_0_1_0_0_1100;
  localparam logic [14:0] E_MEMOP_EX = 15'b1_0_0_1_0_0_0_0_0_0_0_0010;
  localparam logic [14:0] E_LW_MEM   = 15'b1_0_0_1_1_0_0_0_0_0_0_0010;
  localparam logic [14:0] E_LW_WB    = 15'b1_0_0_1_0_0_1_1_1_0_0_0010;
  localparam logic [14:0] E_SW_MEM   = 15'b1_0_0_1_0_1_0_0_1_0_0_0010;

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b1;
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    set_instr(R_TYPE, 3'b000, 7'b0000000);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_IDLE) begin
        $display("FAIL reset_hold c%0d got=%b want=%b", i, obs, E_IDLE);
        errors++;
      end
      next_cycle();
    end
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE) begin
      $display("FAIL reset_release got=%b want=%b", obs, E_IDLE);
      errors++;
    end
    next_cycle();
    $display("reset: outputs held at zero");
  endtask

  // add x3,x1,x2 with zero-wait memory; run dropped after the start cycle.
  task automatic test_add();
    logic [14:0] exp_q[$];
    exp_q = '{E_IDLE, E_FETCH_R, E_DECODE, E_ADD_EX, E_ADD_WB, E_IDLE, E_IDLE, E_IDLE};
    set_instr(R_TYPE, 3'b000, 7'b0000000);
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        $display("FAIL add c%0d got=%b want=%b", i, obs, exp_q[i]);
        errors++;
      end
      next_cycle();
    end
    $display("add: 5-cycle instruction, then idle held with run=0");
  endtask

  // sub then xori back to back (run held through the intermediate IDLE).
  task automatic test_back_to_back();
    logic [14:0] exp_q[$];
    exp_q = '{E_IDLE, E_FETCH_R, E_DECODE, E_SUB_EX, E_SUB_WB, E_IDLE,
              E_FETCH_R, E_DECODE, E_XORI_EX, E_XORI_WB, E_IDLE, E_IDLE};
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i <= 5);
      if (i <= 5) set_instr(R_TYPE, 3'b000, 7'b0100000);
      else        set_instr(RTYPE_I, 3'b100, 7'b0100000);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        $display("FAIL sub_xori c%0d got=%b want=%b", i, obs, exp_q[i]);
        errors++;
      end
      next_cycle();
    end
    $display("sub/xori: back-to-back pair");
  endtask

  // LW with mem_ready arriving on the 4th MEM cycle: 9 cycles total.
  task automatic test_lw_wait();
    logic [14:0] exp_q[$];
    exp_q = '{E_IDLE, E_FETCH_R, E_DECODE, E_MEMOP_EX, E_LW_MEM, E_LW_MEM,
              E_LW_MEM, E_LW_MEM, E_LW_WB, E_IDLE};
    set_instr(LW, 3'b010, 7'b0000000);
    bus.fetch_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i == 0);
      bus.mem_ready = (i == 7);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        $display("FAIL lw_wait c%0d got=%b want=%b", i, obs, exp_q[i]);
        errors++;
      end
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    $display("lw: 3 wait states in MEM");
  endtask

  task automatic test_sw();
    logic [14:0] exp_q[$];
    exp_q = '{E_IDLE, E_FETCH_R, E_DECODE, E_MEMOP_EX, E_SW_MEM, E_IDLE, E_IDLE};
    set_instr(SW, 3'b010, 7'b0000000);
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        $display("FAIL sw c%0d got=%b want=%b", i, obs, exp_q[i]);
        errors++;
      end
      next_cycle();
    end
    $display("sw: zero-wait store");
  endtask

  task automatic test_illegal_branch();
    logic [14:0] exp_q[$];
    exp_q = '{E_IDLE, E_FETCH_R, E_DECODE, E_ILLEGAL, E_IDLE};
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        $display("FAIL illegal_branch c%0d got=%b want=%b", i, obs, exp_q[i]);
        errors++;
      end
      next_cycle();
    end
    $display("branch opcode: illegal pulse");
  endtask

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic [3:0] cc;
  } dec_vec_t;

  // Decode table: at the EXEC cycle a legal instruction shows {busy=1, cc},
  // an illegal one shows {busy=0, illegal=1}.
  task automatic test_decode();
    dec_vec_t vecs[$];
    logic [5:0] want;
    logic       done;
    vecs = '{
      '{R_TYPE,  3'b110, 7'b0000000, 1'b1, 4'b0001},
      '{R_TYPE,  3'b111, 7'b0000000, 1'b1, 4'b0000},
      '{R_TYPE,  3'b010, 7'b0000000, 1'b1, 4'b0111},
      '{R_TYPE,  3'b100, 7'b0000000, 1'b1, 4'b1100},
      '{R_TYPE,  3'b100, 7'b0100000, 1'b0, 4'b0000},
      '{R_TYPE,  3'b001, 7'b0000000, 1'b0, 4'b0000},
      '{R_TYPE,  3'b000, 7'b0000001, 1'b0, 4'b0000},
      '{RTYPE_I, 3'b000, 7'b1111111, 1'b1, 4'b0010},
      '{RTYPE_I, 3'b010, 7'b0000000, 1'b1, 4'b0111},
      '{RTYPE_I, 3'b111, 7'b0000000, 1'b1, 4'b0000},
      '{RTYPE_I, 3'b110, 7'b0100000, 1'b1, 4'b0001},
      '{RTYPE_I, 3'b001, 7'b0000000, 1'b0, 4'b0000},
      '{LW,      3'b000, 7'b0000000, 1'b0, 4'b0000},
      '{SW,      3'b010, 7'b0000000, 1'b1, 4'b0010}
    };
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b1;
    for (int v = 0; v < vecs.size(); v++) begin
      set_instr(vecs[v].op, vecs[v].f3, vecs[v].f7);
      run = 1'b1;
      next_cycle();
      run = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      want = vecs[v].legal ? {1'b1, 1'b0, vecs[v].cc} : {1'b0, 1'b1, 4'b0000};
      checks++;
      if ({busy, illegal, alu_cc} !== want) begin
        $display("FAIL decode v%0d op=%b f3=%b f7=%b got=%b want=%b",
                 v, vecs[v].op, vecs[v].f3, vecs[v].f7, {busy, illegal, alu_cc}, want);
        errors++;
      end
      done = 1'b0;
      for (int k = 0; k < 6 && !done; k++) begin
        next_cycle();
        @(negedge clk);
        if (!busy) done = 1'b1;
      end
      checks++;
      if (!done) begin
        $display("FAIL decode_return v%0d got=busy want=idle within 6 cycles", v);
        errors++;
      end
      next_cycle();
      $display("decode v%0d op=%b f3=%b f7=%b legal=%0b", v, vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].legal);
    end
  endtask

  // fetch_ready never comes: 16 FETCH cycles, then bus_err pulse in IDLE.
  task automatic test_fetch_timeout();
    logic [14:0] want;
    set_instr(R_TYPE, 3'b000, 7'b0000000);
    bus.fetch_ready = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      run = (i == 0);
      if (i == 0)       want = E_IDLE;
      else if (i <= 16) want = E_FETCH_W;
      else if (i == 17) want = E_BUS_ERR;
      else              want = E_IDLE;
      @(negedge clk);
      checks++;
      if (obs !== want) begin
        $display("FAIL fetch_timeout c%0d got=%b want=%b", i, obs, want);
        errors++;
      end
      next_cycle();
    end
    bus.fetch_ready = 1'b1;
    $display("fetch timeout: bus_err after 16 cycles");
  endtask

  // fetch_ready on the 16th (last allowed) FETCH cycle is accepted.
  task automatic test_fetch_last_cycle();
    logic [14:0] want;
    set_instr(R_TYPE, 3'b000, 7'b0000000);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      run = (i == 0);
      bus.fetch_ready = (i == 16);
      if (i == 0)       want = E_IDLE;
      else if (i <= 15) want = E_FETCH_W;
      else if (i == 16) want = E_FETCH_R;
      else if (i == 17) want = E_DECODE;
      else if (i == 18) want = E_ADD_EX;
      else if (i == 19) want = E_ADD_WB;
      else              want = E_IDLE;
      @(negedge clk);
      checks++;
      if (obs !== want) begin
        $display("FAIL fetch_last c%0d got=%b want=%b", i, obs, want);
        errors++;
      end
      next_cycle();
    end
    bus.fetch_ready = 1'b1;
    $display("fetch ready on final allowed cycle: accepted");
  endtask

  // LW whose mem_ready never arrives: 16 MEM cycles, bus_err, no write-back.
  task automatic test_mem_timeout();
    logic [14:0] want;
    set_instr(LW, 3'b010, 7'b0000000);
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      run = (i == 0);
      if (i == 0)       want = E_IDLE;
      else if (i == 1)  want = E_FETCH_R;
      else if (i == 2)  want = E_DECODE;
      else if (i == 3)  want = E_MEMOP_EX;
      else if (i <= 19) want = E_LW_MEM;
      else if (i == 20) want = E_BUS_ERR;
      else              want = E_IDLE;
      @(negedge clk);
      checks++;
      if (obs !== want) begin
        $display("FAIL mem_timeout c%0d got=%b want=%b", i, obs, want);
        errors++;
      end
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    $display("mem timeout: bus_err after 16 cycles");
  endtask

  // Asynchronous reset asserted in the middle of a MEM wait.
  task automatic test_reset_mid_mem();
    set_instr(LW, 3'b010, 7'b0000000);
    bus.fetch_ready = 1'b1;
    bus.mem_ready = 1'b0;
    run = 1'b1;
    next_cycle();
    run = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== E_LW_MEM) begin
      $display("FAIL reset_mid_mem_pre got=%b want=%b", obs, E_LW_MEM);
      errors++;
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      $display("FAIL reset_mid_mem_async got=%b want=%b", obs, E_IDLE);
      errors++;
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE) begin
      $display("FAIL reset_mid_mem_hold got=%b want=%b", obs, E_IDLE);
      errors++;
    end
    next_cycle();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_IDLE) begin
      $display("FAIL reset_mid_mem_after got=%b want=%b", obs, E_IDLE);
      errors++;
    end
    next_cycle();
    $display("reset mid-MEM: outputs cleared immediately");
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    bus.fetch_ready = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(7'b0000000, 3'b000, 7'b0000000);
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_wait();
    test_sw();
    test_illegal_branch();
    test_decode();
    test_fetch_timeout();
    test_fetch_last_cycle();
    test_mem_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
